deriv_scheduler: RTL and testbench

- Sequencing controller for the cepstral derivative unit.
- Accepts a valid/ready stream of 32-bit cepstral coefficients and issues them to the unit only when the unit can sample.
- Mirrors the unit's internal index so it can insert the unit's derivative gap cycles, then tags every unit output word (CEP/DCEP/DDCEP, in-frame index, frame end).
- Buffers the tagged words in an output FIFO with backpressure. Sits between the frame/cepstrum stage and downstream feature storage.

---
 rtl/deriv_scheduler.sv | 128 ++++++++++++
 tb/tb_deriv_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deriv_scheduler.sv
// deriv_scheduler: issues coefficients to the derivative unit, tags its output words and buffers them in a FWFT FIFO
module deriv_scheduler #(
  parameter int DEPTH = 16,
  parameter int FRAME_LEN = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] dm_data_in,
  output logic        dm_valid_in,
  input  logic [31:0] dm_data_out,
  input  logic        dm_valid_out,
  output logic [31:0] m_data,
  output logic [1:0]  m_kind,
  output logic [5:0]  m_index,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        sync_err,
  output logic [15:0] frames_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = AW + 1;
  typedef enum logic {RUN, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] gcnt_q, gcnt_d, gtot_q, gtot_d, g, rel_q, rel_d;
  logic [5:0] k_q, k_d, idx_q, idx_d, cidx_q, cidx_d;
  logic clast_q, clast_d, dv_q, dv_d, uv_q, uv_d, err_q, err_d;
  logic [RW-1:0] res_q, res_d, cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [31:0] dd_q, dd_d, ud_q, ud_d;
  logic [9:0] t0_q, t0_d, t1_q, t2_q;
  logic [15:0] fd_q, fd_d;
  logic [40:0] mem_q [DEPTH];
  logic acc, pop, wr, lost;
  assign dm_valid_in = dv_q;
  assign dm_data_in = dd_q;
  assign sync_err = err_q;
  assign frames_done = fd_q;
  // issue sequencing, tag generation (tag = {valid, kind, index, last}), credit and FIFO bookkeeping
  always_comb begin
    g = (k_q < 6'd2) ? 2'd0 : (k_q < 6'd4) ? 2'd1 : 2'd2;
    s_ready = (rel_q != 2'd0) && (state_q == RUN) && (32'(res_q) + 32'd3 <= 32'(DEPTH));
    m_valid = cnt_q != '0;
    acc = s_valid && s_ready;
    pop = m_valid && m_ready;
    wr = uv_q && t2_q[9];
    lost = t2_q[9] && !uv_q;
    rel_d = (rel_q == 2'd2) ? rel_q : rel_q + 2'd1;
    dv_d = acc;
    dd_d = acc ? s_data : dd_q;
    uv_d = dm_valid_out && (rel_q == 2'd2);
    ud_d = dm_data_out;
    k_d = k_q + 6'(acc);
    idx_d = !acc ? idx_q : (s_last || idx_q == 6'(FRAME_LEN - 1)) ? 6'd0 : idx_q + 6'd1;
    err_d = err_q || (uv_q != t2_q[9]) || (acc && !s_last && idx_q == 6'(FRAME_LEN - 1));
    state_d = (acc && g != 2'd0) ? GAP : (state_q == GAP && gcnt_q == 2'd1) ? RUN : state_q;
    gcnt_d = acc ? g : (state_q == GAP) ? gcnt_q - 2'd1 : gcnt_q;
    gtot_d = acc ? g : gtot_q;
    cidx_d = acc ? idx_q : cidx_q;
    clast_d = acc ? s_last : clast_q;
    t0_d = acc ? {1'b1, 2'd0, idx_q, s_last && g == 2'd0}
         : (state_q == GAP) ? {1'b1, (gcnt_q == gtot_q) ? 2'd1 : 2'd2, cidx_q, clast_q && gcnt_q == 2'd1}
         : 10'd0;
    res_d = res_q + (acc ? RW'(g) + RW'(1) : RW'(0)) - RW'(pop) - RW'(lost);
    cnt_d = cnt_q + RW'(wr) - RW'(pop);
    wp_d = wp_q + AW'(wr);
    rp_d = rp_q + AW'(pop);
    fd_d = fd_q + 16'(wr && t2_q[0]);
    m_data = m_valid ? mem_q[rp_q][40:9] : 32'd0;
    m_kind = m_valid ? mem_q[rp_q][8:7] : 2'd0;
    m_index = m_valid ? mem_q[rp_q][6:1] : 6'd0;
    m_last = m_valid && mem_q[rp_q][0];
  end
  // control state with async clear; tags are delayed twice to line up with the captured unit output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      gcnt_q <= '0;
      gtot_q <= '0;
      rel_q <= '0;
      k_q <= '0;
      idx_q <= '0;
      cidx_q <= '0;
      clast_q <= 1'b0;
      dv_q <= 1'b0;
      dd_q <= '0;
      uv_q <= 1'b0;
      ud_q <= '0;
      err_q <= 1'b0;
      res_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      fd_q <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q <= gcnt_d;
      gtot_q <= gtot_d;
      rel_q <= rel_d;
      k_q <= k_d;
      idx_q <= idx_d;
      cidx_q <= cidx_d;
      clast_q <= clast_d;
      dv_q <= dv_d;
      dd_q <= dd_d;
      uv_q <= uv_d;
      ud_q <= ud_d;
      err_q <= err_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      t0_q <= t0_d;
      t1_q <= t0_q;
      t2_q <= t1_q;
      fd_q <= fd_d;
    end
  // FIFO storage: {data, kind, index, last}
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= {ud_q, t2_q[8:0]};
endmodule

// File: tb/tb_deriv_scheduler.sv
// tb_deriv_scheduler: directed + random stimulus against a queue-based reference model and a behavioural derivative unit
module tb_deriv_scheduler;
  localparam int DEPTH = 16;
  localparam int FRAME_LEN = 13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] dm_data_in, dm_data_out;
  logic dm_valid_in, dm_valid_out;
  logic [31:0] m_data;
  logic [1:0] m_kind;
  logic [5:0] m_index;
  logic m_last, m_valid;
  logic m_ready = 1'b0;
  logic sync_err;
  logic [15:0] frames_done;

  deriv_scheduler #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .dm_data_in(dm_data_in), .dm_valid_in(dm_valid_in), .dm_data_out(dm_data_out), .dm_valid_out(dm_valid_out),
    .m_data(m_data), .m_kind(m_kind), .m_index(m_index), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .sync_err(sync_err), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  typedef struct {logic [31:0] d; logic [1:0] kind; logic [5:0] idx; logic last;} w_t;
  w_t q[$];
  int mk = 0, mf = 0, gap_left = 0, frames_exp = 0;
  logic exp_err = 1'b0, mr = 1'b1, spur = 1'b0, acc = 1'b0;

  // behavioural derivative unit: one cycle latency, emits CEP then its derivative words
  int uk = 0;
  logic [31:0] uq[$];
  logic uv = 1'b0;
  logic [31:0] ud = '0;
  assign dm_valid_out = uv | spur;
  assign dm_data_out = ud;
  always @(posedge clk) begin
    if (!rst_n) uk = 0;
    else if (dm_valid_in) begin
      uq.push_back(dm_data_in);
      if (uk >= 2) uq.push_back(~dm_data_in);
      if (uk >= 4) uq.push_back(dm_data_in ^ 32'h5a5a5a5a);
      uk = (uk + 1) % 64;
    end
    uv <= uq.size() > 0;
    if (uq.size() > 0) ud <= uq.pop_front();
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(int k);
    return k < 2 ? 0 : k < 4 ? 1 : 2;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic l);
    int g;
    w_t w;
    g = gap_of(mk);
    for (int j = 0; j <= g; j++) begin
      w.d = j == 0 ? d : j == 1 ? ~d : d ^ 32'h5a5a5a5a;
      w.kind = 2'(j);
      w.idx = 6'(mf);
      w.last = l && j == g;
      if (w.last) frames_exp++;
      q.push_back(w);
    end
    mk = (mk + 1) % 64;
    gap_left = g;
    if (l) mf = 0;
    else if (mf == FRAME_LEN - 1) begin
      mf = 0;
      exp_err = 1'b1;
    end else mf++;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l);
    @(negedge clk);
    s_valid = v;
    s_data = d;
    s_last = l;
    m_ready = mr;
    #1;
    chk("s_ready", s_ready, gap_left == 0 && q.size() + 3 <= DEPTH);
    if (q.size() == 0) chk("fifo_empty", m_valid, 0);
    else if (m_valid) begin
      chk("word", {m_data, m_kind, m_index, m_last}, {q[0].d, q[0].kind, q[0].idx, q[0].last});
      if (m_ready) void'(q.pop_front());
    end
    acc = v && s_ready;
    if (acc) model_accept(d, l);
    else if (gap_left > 0) gap_left--;
  endtask

  task automatic send(input logic [31:0] d, input logic l, output int n);
    n = 0;
    do begin
      step(1'b1, d, l);
      n++;
    end while (!acc && n < 64);
    chk("send_acc", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    mr = 1'b1;
    while (q.size() > 0 && n < 400) begin
      step(1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_empty", q.size() == 0, 1);
    repeat (4) step(1'b0, '0, 1'b0);
    chk("quiet_m_valid", m_valid, 0);
    chk("frames_done", frames_done, 64'(frames_exp % 65536));
    chk("sync_err", sync_err, exp_err);
  endtask

  task automatic do_reset(input logic sp);
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    #1;
    q.delete();
    mk = 0;
    mf = 0;
    gap_left = 0;
    frames_exp = 0;
    exp_err = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dm_valid", dm_valid_in, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_sync_err", sync_err, 0);
    repeat (3) @(negedge clk);
    chk("rst_hold_ready", s_ready, 0);
    rst_n = 1'b1;
    spur = sp;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    spur = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset(1'b0);
    // single-sample frame: issue strobe and latency
    step(1'b1, 32'hcafe0001, 1'b1);
    chk("acc_first", acc, 1);
    step(1'b0, '0, 1'b0);
    chk("issue_v", dm_valid_in, 1);
    chk("issue_d", dm_data_in, 32'hcafe0001);
    step(1'b0, '0, 1'b0);
    chk("issue_once", dm_valid_in, 0);
    step(1'b0, '0, 1'b0);
    chk("lat_t2", m_valid, 0);
    step(1'b0, '0, 1'b0);
    chk("lat_t3", m_valid, 1);
    drain();
    // four back-to-back samples: gaps after k=2 and k=3
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      send(32'h10 * (i + 1), 1'b0, n);
      chk("bb_wait", n, i == 3 ? 2 : 1);
    end
    step(1'b0, '0, 1'b0);
    chk("bb_gap", s_ready, 0);
    step(1'b0, '0, 1'b0);
    chk("bb_run", s_ready, 1);
    drain();
    // six-sample frame ending with s_last on a g=2 sample
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send(32'h100 + i, i == 5, n);
    chk("fd_before", frames_done, 0);
    drain();
    // backpressure: accepts stall on credit, then drain in order
    mr = 1'b0;
    for (int i = 0; i < 30; i++) step(1'b1, $urandom, mf == FRAME_LEN - 1);
    chk("ovf_stalled", s_ready, 0);
    chk("ovf_m_valid", m_valid, 1);
    drain();
    // shadow index wrap: k=0 and k=1 after wrap need no gap
    do_reset(1'b0);
    for (int i = 0; i < 67; i++) begin
      send($urandom, i % 10 == 9, n);
      if (i == 64) chk("wrap_k0_wait", n, 3);
      if (i >= 65) chk("wrap_nogap", n, 1);
    end
    drain();
    // frame overrun
    do_reset(1'b0);
    for (int i = 0; i < FRAME_LEN; i++) send(32'h200 + i, 1'b0, n);
    drain();
    // random traffic
    do_reset(1'b0);
    for (int i = 0; i < 600; i++) begin
      mr = $urandom_range(0, 2) != 0;
      step($urandom_range(0, 3) != 0, $urandom, mf == FRAME_LEN - 1 || $urandom_range(0, 7) == 0);
    end
    drain();
    // spurious unit output with nothing pending
    do_reset(1'b0);
    drain();
    spur = 1'b1;
    step(1'b0, '0, 1'b0);
    spur = 1'b0;
    exp_err = 1'b1;
    drain();
    chk("err_sticky", sync_err, 1);
    // reset mid-GAP with three words queued, in-flight output in the discard window
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) send(32'h300 + i, 1'b0, n);
    drain();
    mr = 1'b0;
    send(32'h400, 1'b0, n);
    repeat (4) step(1'b0, '0, 1'b0);
    send(32'h500, 1'b0, n);
    step(1'b0, '0, 1'b0);
    chk("pre_m_valid", m_valid, 1);
    chk("pre_gap", s_ready, 0);
    do_reset(1'b1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
